// File: rtl/pwm_deadtime_driver.sv
// Complementary high/low gate driver with break-before-make dead time, latched fault shutdown and pulse counter.
// Optional macro PWM_DT_GLITCH_FILTER_EN adds a two-cycle-agreement filter on the registered PWM input.
module pwm_deadtime_driver #(
  parameter int DT_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 i_pwm_in,
  input  logic [DT_WIDTH-1:0]  i_dead_cycles,
  input  logic                 i_fault_in,
  input  logic                 i_fault_clr,
  output logic                 o_out_hi,
  output logic                 o_out_lo,
  output logic                 o_fault_latched,
  output logic [CNT_WIDTH-1:0] o_pulse_count
);

  typedef enum logic [2:0] {
    IDLE,
    DT_TO_HI,
    HI_ON,
    DT_TO_LO,
    LO_ON,
    FAULT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DT_WIDTH-1:0] r_dead_cnt;
  logic [DT_WIDTH-1:0] w_dead_next;
  logic                r_pwm_q;
  logic                r_fault_meta;
  logic                r_fault_s;
  logic                w_pwm;
  logic                w_cnt_clr;
  logic                w_cnt_inc;

  // fault_in is asynchronous, so it gets a two-flop synchroniser; pwm_in is already clk-synchronous
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_q      <= 1'b0;
      r_fault_meta <= 1'b0;
      r_fault_s    <= 1'b0;
    end else begin
      r_pwm_q      <= i_pwm_in;
      r_fault_meta <= i_fault_in;
      r_fault_s    <= r_fault_meta;
    end
  end

`ifdef PWM_DT_GLITCH_FILTER_EN
  logic r_pwm_d;
  logic r_pwm_hold;

  // A new level is only believed once two consecutive samples of pwm_q agree on it
  assign w_pwm = (r_pwm_q == r_pwm_d) ? r_pwm_q : r_pwm_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_d    <= 1'b0;
      r_pwm_hold <= 1'b0;
    end else begin
      r_pwm_d    <= r_pwm_q;
      r_pwm_hold <= w_pwm;
    end
  end
`else
  assign w_pwm = r_pwm_q;
`endif

  // Fault beats enable, enable beats normal sequencing; a reversal during dead time restarts the opposite dead time
  always_comb begin
    w_next      = r_state;
    w_dead_next = r_dead_cnt;
    w_cnt_clr   = 1'b0;
    if (r_fault_s) begin
      w_next = FAULT;
    end else if (r_state == FAULT) begin
      if (i_fault_clr) begin
        w_next    = IDLE;
        w_cnt_clr = 1'b1;
      end
    end else if (!i_enable) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_next      = w_pwm ? DT_TO_HI : DT_TO_LO;
          w_dead_next = i_dead_cycles;
        end
        DT_TO_HI: begin
          if (!w_pwm) begin
            w_next      = DT_TO_LO;
            w_dead_next = i_dead_cycles;
          end else if (r_dead_cnt == '0) begin
            w_next = HI_ON;
          end else begin
            w_dead_next = r_dead_cnt - DT_WIDTH'(1);
          end
        end
        DT_TO_LO: begin
          if (w_pwm) begin
            w_next      = DT_TO_HI;
            w_dead_next = i_dead_cycles;
          end else if (r_dead_cnt == '0) begin
            w_next = LO_ON;
          end else begin
            w_dead_next = r_dead_cnt - DT_WIDTH'(1);
          end
        end
        HI_ON: begin
          if (!w_pwm) begin
            w_next      = DT_TO_LO;
            w_dead_next = i_dead_cycles;
          end
        end
        LO_ON: begin
          if (w_pwm) begin
            w_next      = DT_TO_HI;
            w_dead_next = i_dead_cycles;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  assign w_cnt_inc = (w_next == HI_ON) && (r_state != HI_ON);

  // Gate outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_dead_cnt      <= '0;
      o_out_hi        <= 1'b0;
      o_out_lo        <= 1'b0;
      o_fault_latched <= 1'b0;
      o_pulse_count   <= '0;
    end else begin
      r_state         <= w_next;
      r_dead_cnt      <= w_dead_next;
      o_out_hi        <= (w_next == HI_ON);
      o_out_lo        <= (w_next == LO_ON);
      o_fault_latched <= (w_next == FAULT);
      if (w_cnt_clr) begin
        o_pulse_count <= '0;
      end else if (w_cnt_inc) begin
        o_pulse_count <= o_pulse_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed scoreboard bench for pwm_deadtime_driver; a second instance with a 4-bit counter exercises wrap-around.
// Builds with or without PWM_DT_GLITCH_FILTER_EN; expected latencies shift by one cycle when the filter is on.
module tb_pwm_deadtime_driver;

`ifdef PWM_DT_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        pwmIn;
  logic [7:0]  deadCycles;
  logic        faultIn;
  logic        faultClr;
  logic        outHi;
  logic        outLo;
  logic        faultLatched;
  logic [15:0] pulseCount;
  logic        outHiSmall;
  logic        outLoSmall;
  logic        faultLatchedSmall;
  logic [3:0]  pulseCountSmall;

  typedef struct {
    string       tag;
    logic        hi;
    logic        lo;
    logic        flt;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] modelCount = 16'd0;

  pwm_deadtime_driver #(.DT_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_pwm_in       (pwmIn),
    .i_dead_cycles  (deadCycles),
    .i_fault_in     (faultIn),
    .i_fault_clr    (faultClr),
    .o_out_hi       (outHi),
    .o_out_lo       (outLo),
    .o_fault_latched(faultLatched),
    .o_pulse_count  (pulseCount)
  );

  pwm_deadtime_driver #(.DT_WIDTH(8), .CNT_WIDTH(4)) dutSmall (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_pwm_in       (pwmIn),
    .i_dead_cycles  (deadCycles),
    .i_fault_in     (faultIn),
    .i_fault_clr    (faultClr),
    .o_out_hi       (outHiSmall),
    .o_out_lo       (outLoSmall),
    .o_fault_latched(faultLatchedSmall),
    .o_pulse_count  (pulseCountSmall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic checkVec(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic pushExpected(input string tag, input logic eh, input logic el, input logic ef);
    exp_t e;
    e.tag = tag;
    e.hi  = eh;
    e.lo  = el;
    e.flt = ef;
    e.cnt = modelCount;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] smallExp;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    smallExp = {12'd0, e.cnt[3:0]};
    checkBit({e.tag, "/hi"}, outHi, e.hi);
    checkBit({e.tag, "/lo"}, outLo, e.lo);
    checkBit({e.tag, "/fault"}, faultLatched, e.flt);
    checkVec({e.tag, "/count"}, pulseCount, e.cnt);
    checkBit({e.tag, "/overlap"}, outHi & outLo, 1'b0);
    checkBit({e.tag, "/hiSmall"}, outHiSmall, e.hi);
    checkBit({e.tag, "/loSmall"}, outLoSmall, e.lo);
    checkBit({e.tag, "/faultSmall"}, faultLatchedSmall, e.flt);
    checkVec({e.tag, "/countSmall"}, {12'd0, pulseCountSmall}, smallExp);
  endtask

  task automatic applyStimulus(input string tag, input logic eh, input logic el, input logic ef);
    pushExpected(tag, eh, el, ef);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic repeatStep(input int n, input string tag, input logic eh, input logic el, input logic ef);
    for (int i = 0; i < n; i++) applyStimulus(tag, eh, el, ef);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    pwmIn      = 1'b0;
    deadCycles = 8'd3;
    faultIn    = 1'b0;
    faultClr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pushExpected("reset", 1'b0, 1'b0, 1'b0);
    checkOutput();
    rst_n = 1'b1;

    // Leave IDLE towards the low side: four dead cycles, then out_lo
    enable = 1'b1;
    repeatStep(4, "t1_dead", 1'b0, 1'b0, 1'b0);
    applyStimulus("t1_lo", 1'b0, 1'b1, 1'b0);

    // Rising transition; dead_cycles changed mid-dead-time must be ignored
    pwmIn = 1'b1;
    repeatStep(1 + FILT, "t2_pre", 1'b0, 1'b1, 1'b0);
    applyStimulus("t2_dead", 1'b0, 1'b0, 1'b0);
    deadCycles = 8'd7;
    repeatStep(3, "t2_dead", 1'b0, 1'b0, 1'b0);
    deadCycles = 8'd3;
    modelCount++;
    applyStimulus("t2_hi", 1'b1, 1'b0, 1'b0);
    repeatStep(2, "t2_hold", 1'b1, 1'b0, 1'b0);

    // Falling transition is symmetric
    pwmIn = 1'b0;
    repeatStep(1 + FILT, "t2f_pre", 1'b1, 1'b0, 1'b0);
    repeatStep(4, "t2f_dead", 1'b0, 1'b0, 1'b0);
    applyStimulus("t2f_lo", 1'b0, 1'b1, 1'b0);

    // A 4-cycle pulse is shorter than dead_cycles+1 = 6 and must never reach out_hi
    deadCycles = 8'd5;
    pwmIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 1 + FILT) applyStimulus("t3_pre", 1'b0, 1'b1, 1'b0);
      else              applyStimulus("t3_dead", 1'b0, 1'b0, 1'b0);
    end
    pwmIn = 1'b0;
    repeatStep(7 + FILT, "t3_dead", 1'b0, 1'b0, 1'b0);
    applyStimulus("t3_lo", 1'b0, 1'b1, 1'b0);

    // Reach HI_ON with one-cycle-plus-one dead time, then fault
    deadCycles = 8'd1;
    pwmIn = 1'b1;
    repeatStep(1 + FILT, "t4_pre", 1'b0, 1'b1, 1'b0);
    repeatStep(2, "t4_dead", 1'b0, 1'b0, 1'b0);
    modelCount++;
    applyStimulus("t4_hi", 1'b1, 1'b0, 1'b0);
    faultIn = 1'b1;
    repeatStep(2, "t4_sync", 1'b1, 1'b0, 1'b0);
    applyStimulus("t4_fault", 1'b0, 1'b0, 1'b1);
    faultClr = 1'b1;
    applyStimulus("t4_clrHeld", 1'b0, 1'b0, 1'b1);
    faultClr = 1'b0;
    enable = 1'b0;
    applyStimulus("t4_enIgnored", 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    faultIn = 1'b0;
    repeatStep(2, "t4_unsync", 1'b0, 1'b0, 1'b1);
    applyStimulus("t4_noClr", 1'b0, 1'b0, 1'b1);
    faultClr = 1'b1;
    modelCount = 16'd0;
    applyStimulus("t4_clr", 1'b0, 1'b0, 1'b0);
    faultClr = 1'b0;
    repeatStep(2, "t4_reDead", 1'b0, 1'b0, 1'b0);
    modelCount++;
    applyStimulus("t4_reHi", 1'b1, 1'b0, 1'b0);
    faultClr = 1'b1;
    applyStimulus("t4_clrOutside", 1'b1, 1'b0, 1'b0);
    faultClr = 1'b0;

    // Drop enable during DT_TO_HI; re-enabling must restart the full dead time
    deadCycles = 8'd3;
    pwmIn = 1'b0;
    repeatStep(1 + FILT, "t5_fallPre", 1'b1, 1'b0, 1'b0);
    repeatStep(4, "t5_fallDead", 1'b0, 1'b0, 1'b0);
    applyStimulus("t5_lo", 1'b0, 1'b1, 1'b0);
    pwmIn = 1'b1;
    repeatStep(1 + FILT, "t5_pre", 1'b0, 1'b1, 1'b0);
    applyStimulus("t5_dtHi", 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    repeatStep(2, "t5_idle", 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    repeatStep(4, "t5_reDead", 1'b0, 1'b0, 1'b0);
    modelCount++;
    applyStimulus("t5_hi", 1'b1, 1'b0, 1'b0);

    pwmIn = 1'b0;
    repeatStep(1 + FILT, "t6_fallPre", 1'b1, 1'b0, 1'b0);
    repeatStep(4, "t6_fallDead", 1'b0, 1'b0, 1'b0);
    applyStimulus("t6_lo", 1'b0, 1'b1, 1'b0);
`ifdef PWM_DT_GLITCH_FILTER_EN
    pwmIn = 1'b1;
    applyStimulus("t6_glitch", 1'b0, 1'b1, 1'b0);
    pwmIn = 1'b0;
    repeatStep(4, "t6_glitchHold", 1'b0, 1'b1, 1'b0);
`endif

    // Sixteen minimum-dead-time pulses: the 4-bit instance wraps through zero
    deadCycles = 8'd0;
    for (int p = 0; p < 16; p++) begin
      pwmIn = 1'b1;
      repeatStep(1 + FILT, "t7_rPre", 1'b0, 1'b1, 1'b0);
      applyStimulus("t7_rDead", 1'b0, 1'b0, 1'b0);
      modelCount++;
      applyStimulus("t7_hi", 1'b1, 1'b0, 1'b0);
      pwmIn = 1'b0;
      repeatStep(1 + FILT, "t7_fPre", 1'b1, 1'b0, 1'b0);
      applyStimulus("t7_fDead", 1'b0, 1'b0, 1'b0);
      applyStimulus("t7_lo", 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset while driving high: outputs drop without waiting for a clock edge
    pwmIn = 1'b1;
    repeatStep(1 + FILT, "t8_pre", 1'b0, 1'b1, 1'b0);
    applyStimulus("t8_dead", 1'b0, 1'b0, 1'b0);
    modelCount++;
    applyStimulus("t8_hi", 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    modelCount = 16'd0;
    pushExpected("t8_asyncReset", 1'b0, 1'b0, 1'b0);
    checkOutput();
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
- Sits directly downstream of the PWM generator in the SPI-controlled PWM top level.
- Consumes the single-ended pwm signal and produces a complementary high-side/low-side gate pair with programmable break-before-make dead time.
- Also provides a latched fault shutdown and a count of high-side pulses delivered.
- All inputs except fault_in are synchronous to clk.

Parameters:
DT_WIDTH, 8, width of dead_cycles and the internal dead-time counter
CNT_WIDTH, 16, width of pulse_count

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  1 = drive outputs from pwm_in; 0 = both outputs off
pwm_in  input  1  PWM from generator, clk-synchronous
dead_cycles  input  DT_WIDTH  dead time; both outputs low for dead_cycles+1 cycles per transition
fault_in  input  1  asynchronous external fault, active-high
fault_clr  input  1  single-cycle request to leave fault state
out_hi  output  1  high-side gate, registered
out_lo  output  1  low-side gate, registered
fault_latched  output  1  1 while in FAULT state, registered
pulse_count  output  CNT_WIDTH  number of entries into HI_ON, registered

Behaviour:
- Reset values: out_hi=0, out_lo=0, fault_latched=0, pulse_count=0, state IDLE, dead counter 0, internal pwm_q=0, fault synchroniser=0.
- Input registering:
  - pwm_in is registered once into pwm_q; all decisions use pwm_q.
  - fault_in passes through a 2-flop synchroniser to produce fault_s.
- States: IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON, FAULT.
- Outputs are registered from the next state:
  - out_hi=1 only in HI_ON; out_lo=1 only in LO_ON.
  - out_hi and out_lo are never 1 in the same cycle.
- Priority order, evaluated every cycle:
  - 1) fault_s=1: go to FAULT from any state.
  - 2) enable=0: go to IDLE.
  - 3) Normal transitions below.
- IDLE, enable=1: pwm_q=1 -> DT_TO_HI, else -> DT_TO_LO. The dead counter loads dead_cycles.
- DT_TO_HI / DT_TO_LO:
  - Counter==0 -> HI_ON / LO_ON respectively; otherwise decrement.
  - Both outputs remain low for exactly dead_cycles+1 cycles.
  - dead_cycles is sampled only on entry; changes mid-dead-time are ignored.
- Direction change during dead time: pwm_q reverses while in DT_TO_HI -> go to DT_TO_LO with the counter reloaded, and vice versa.
- HI_ON: pwm_q=0 -> DT_TO_LO, counter reloaded.
- LO_ON: pwm_q=1 -> DT_TO_HI, counter reloaded.
- Latency from pwm_in rising, starting in LO_ON:
  - out_lo falls 2 clk edges after pwm_in is sampled high.
  - out_hi rises dead_cycles+1 cycles after out_lo falls.
  - The falling direction is symmetric.
- Short pulses: a pwm high pulse of ≤ dead_cycles+1 cycles (measured at pwm_q) never asserts out_hi.
- pulse_count:
  - Increments by 1 on each transition into HI_ON and wraps modulo 2^CNT_WIDTH.
  - Cleared by reset and by an accepted fault_clr.
- FAULT:
  - Both outputs go to 0 on the cycle after fault_s is seen; fault_latched=1.
  - Exit to IDLE only when fault_clr=1 and fault_s=0 in the same cycle.
  - fault_clr is ignored while fault_s=1, and ignored outside FAULT.
  - enable has no effect in FAULT.
- Asynchronous reset mid-operation: outputs drop immediately, with no dead-time sequencing.

Optional Feature:
- Macro PWM_DT_GLITCH_FILTER_EN.
- Defined:
  - An edge of pwm_q is accepted only after pwm_q holds the new level for 2 consecutive cycles.
  - A 1-cycle glitch is ignored.
  - All pwm-driven transitions gain 1 cycle of latency.
- Undefined: pwm_q is used directly; the latency is as stated above.

Test Plan:
- Reset, enable=1, pwm_in=0, dead_cycles=3 -> both low for 4 cycles after IDLE exit, then out_lo=1; pulse_count=0.
- From LO_ON, pwm_in 0->1 held, dead_cycles=3 -> out_lo falls 2 edges after sampling; out_hi rises 4 cycles later; pulse_count=1; overlap checker never fires.
- dead_cycles=5, pwm_in high pulse of 4 cycles -> out_hi stays 0; returns to out_lo=1; pulse_count unchanged.
- HI_ON, assert fault_in -> both outputs 0 within 3 edges; fault_latched=1. fault_clr while fault_in=1 -> no exit. Deassert fault_in, then fault_clr -> IDLE; pulse_count=0.
- 0x0000FFFF pulses with CNT_WIDTH=16 (force the counter to 0xFFFF), one more rising pwm -> pulse_count=0x0000.
- enable 1->0 during DT_TO_HI -> IDLE next cycle, both low. With PWM_DT_GLITCH_FILTER_EN, a 1-cycle pwm_in pulse in LO_ON -> out_lo stays 1.
